// File: rtl/hex_scan_driver.sv
// hex_scan_driver
// Scans two 4-digit multiplexed seven-segment banks from a pair of 16-bit hex
// words. Each digit owns one slot of 2^REFRESH_BITS clocks. A slot opens with
// DEADTIME clocks of all-grids-off to prevent ghosting.
// All four input words are snapshotted once per frame, so the display never
// tears. Optional leading-zero blanking hides high-order zero digits.
// Every output is decoded from flops only; no input reaches an output
// combinationally.
module hex_scan_driver #(
  parameter int REFRESH_BITS = 16,
  parameter int DEADTIME     = 4,
  parameter bit LZB          = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] hex_left_i,
  input  logic [15:0] hex_right_i,
  input  logic [3:0]  dp_left_i,
  input  logic [3:0]  dp_right_i,
  input  logic        blank_i,
  output logic [7:0]  hex_seg_left,
  output logic [3:0]  hex_grid_left,
  output logic [7:0]  hex_seg_right,
  output logic [3:0]  hex_grid_right,
  output logic        frame_o
);

  // Last count of a slot; the counter rolls over to zero after it.
  localparam logic [REFRESH_BITS-1:0] CNT_MAX = {REFRESH_BITS{1'b1}};
  // Dead-time threshold, one bit wider than the counter so that the compare
  // below never truncates.
  localparam logic [REFRESH_BITS:0] DEAD_CLKS = (REFRESH_BITS + 1)'(DEADTIME);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [15:0]             snap_l_q, snap_l_d;
  logic [15:0]             snap_r_q, snap_r_d;
  logic [3:0]              snap_dpl_q, snap_dpl_d;
  logic [3:0]              snap_dpr_q, snap_dpr_d;
  logic                    frame_q, frame_d;
  logic                    blank_q, blank_d;

  logic slot_wrap;
  logic frame_load;

  // Next-state logic: free-running slot counter, digit index and frame snapshot.
  always_comb begin
    slot_wrap  = (cnt_q == CNT_MAX);
    frame_load = slot_wrap && (idx_q == 2'd3);

    cnt_d      = cnt_q + 1'b1;
    idx_d      = slot_wrap ? idx_q + 2'd1 : idx_q;

    // Capture the inputs only at the frame boundary. Changes made mid-frame
    // stay invisible until the next frame starts.
    snap_l_d   = frame_load ? hex_left_i  : snap_l_q;
    snap_r_d   = frame_load ? hex_right_i : snap_r_q;
    snap_dpl_d = frame_load ? dp_left_i   : snap_dpl_q;
    snap_dpr_d = frame_load ? dp_right_i  : snap_dpr_q;

    // frame_q is high in the first clock of the new frame (cnt=0, idx=0).
    frame_d    = frame_load;

    // blank_i passes through one flop so that no input has a direct
    // combinational path to the pins.
    blank_d    = blank_i;
  end

  // State flops. An asynchronous reset aborts the current frame and clears the
  // snapshots, so no partially captured frame survives the reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      snap_l_q   <= 16'h0000;
      snap_r_q   <= 16'h0000;
      snap_dpl_q <= 4'h0;
      snap_dpr_q <= 4'h0;
      frame_q    <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_l_q   <= snap_l_d;
      snap_r_q   <= snap_r_d;
      snap_dpl_q <= snap_dpl_d;
      snap_dpr_q <= snap_dpr_d;
      frame_q    <= frame_d;
      blank_q    <= blank_d;
    end
  end

  assign frame_o = frame_q;

  // ---------------------------------------------------------------------------
  // Seven-segment decode. Segments are active-low; bit0..6 map to a..g.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-bank slot output. Both banks share cnt/idx and scan in lockstep.
  // ---------------------------------------------------------------------------
  logic [15:0] bank_hex  [2];
  logic [3:0]  bank_dp   [2];
  logic [7:0]  bank_seg  [2];
  logic [3:0]  bank_grid [2];
  logic        slot_dark;

  assign bank_hex[0] = snap_l_q;
  assign bank_hex[1] = snap_r_q;
  assign bank_dp[0]  = snap_dpl_q;
  assign bank_dp[1]  = snap_dpr_q;

  // Dead-time at the start of every slot, or a global blank request: both
  // banks go dark together.
  assign slot_dark = ({1'b0, cnt_q} < DEAD_CLKS) || blank_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [3:0] nib;
      logic       lz_blank;
      logic [3:0] grid_b;
      logic [7:0] seg_b;

      assign nib = bank_hex[gi][{idx_q, 2'b00} +: 4];

      // Leading-zero blanking: digit k (k>0) is hidden when nibbles k..3 are
      // all zero. Digit 0 is always shown, so a value of zero still reads "0".
      always_comb begin
        lz_blank = 1'b0;
        case (idx_q)
          2'd1:    lz_blank = LZB && (bank_hex[gi][15:4]  == 12'h000);
          2'd2:    lz_blank = LZB && (bank_hex[gi][15:8]  == 8'h00);
          2'd3:    lz_blank = LZB && (bank_hex[gi][15:12] == 4'h0);
          default: lz_blank = 1'b0;
        endcase
      end

      // Drive the active digit. A blanked digit also suppresses its decimal
      // point, because the grid and all segments are off together.
      always_comb begin
        grid_b = 4'hF;
        seg_b  = 8'hFF;
        if (!slot_dark && !lz_blank) begin
          grid_b = ~(4'b0001 << idx_q);
          seg_b  = {~bank_dp[gi][idx_q], seg_decode(nib)};
        end
      end

      assign bank_seg[gi]  = seg_b;
      assign bank_grid[gi] = grid_b;
    end
  endgenerate

  assign hex_seg_left   = bank_seg[0];
  assign hex_grid_left  = bank_grid[0];
  assign hex_seg_right  = bank_seg[1];
  assign hex_grid_right = bank_grid[1];

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver
// Randomised and directed stimulus for hex_scan_driver. There are two
// instances: one without and one with leading-zero blanking.
// A time-based reference model predicts every cycle's outputs. It works only
// from the clock count since reset and from the frame snapshot. The predicted
// outputs are queued, and a monitor on the falling edge pops and compares them.
module tb_hex_scan_driver;

  localparam int RB   = 3;
  localparam int SLOT = 1 << RB;   // clocks per digit slot
  localparam int FRM  = 4 * SLOT;  // clocks per frame
  localparam int DT   = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] hex_left_i = 16'h0;
  logic [15:0] hex_right_i = 16'h0;
  logic [3:0]  dp_left_i = 4'h0;
  logic [3:0]  dp_right_i = 4'h0;
  logic        blank_i = 1'b0;

  logic [7:0] seg_l, seg_r, zseg_l, zseg_r;
  logic [3:0] grid_l, grid_r, zgrid_l, zgrid_r;
  logic       frame, zframe;

  always #5 clk = ~clk;

  hex_scan_driver #(.REFRESH_BITS(RB), .DEADTIME(DT), .LZB(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .hex_left_i(hex_left_i), .hex_right_i(hex_right_i),
    .dp_left_i(dp_left_i), .dp_right_i(dp_right_i), .blank_i(blank_i),
    .hex_seg_left(seg_l), .hex_grid_left(grid_l),
    .hex_seg_right(seg_r), .hex_grid_right(grid_r), .frame_o(frame)
  );

  hex_scan_driver #(.REFRESH_BITS(RB), .DEADTIME(DT), .LZB(1'b1)) dut_lzb (
    .clk(clk), .reset_n(reset_n),
    .hex_left_i(hex_left_i), .hex_right_i(hex_right_i),
    .dp_left_i(dp_left_i), .dp_right_i(dp_right_i), .blank_i(blank_i),
    .hex_seg_left(zseg_l), .hex_grid_left(zgrid_l),
    .hex_seg_right(zseg_r), .hex_grid_right(zgrid_r), .frame_o(zframe)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [16];
  int         m_t;          // clocks elapsed since reset release
  logic [15:0] m_sl, m_sr;  // frame snapshot
  logic [3:0]  m_dl, m_dr;
  logic        m_blank;     // blank_i as seen at the previous edge
  logic        m_frame;

  typedef struct {
    int         t;
    logic [3:0] gl; logic [7:0] sl; logic [3:0] gr; logic [7:0] sr; logic fr;
    logic [3:0] zgl; logic [7:0] zsl; logic [3:0] zgr; logic [7:0] zsr;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
    seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
    seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
    seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;
  end

  function automatic void model_bank(input logic [15:0] snap, input logic [3:0] dp,
                                     input bit lzb, output logic [3:0] g,
                                     output logic [7:0] s);
    int slot;
    int phase;
    int nib;
    logic [7:0] pat;
    slot  = (m_t / SLOT) % 4;
    phase = m_t % SLOT;
    nib   = int'((snap >> (4 * slot)) & 16'hF);
    g = 4'hF;
    s = 8'hFF;
    if (phase < DT || m_blank) return;
    if (lzb && slot > 0 && (snap >> (4 * slot)) == 16'h0) return;
    pat = seg_tab[nib];
    g = ~(4'b0001 << slot);
    s = {~dp[slot], pat[6:0]};
  endfunction

  // Predictor: advances the model on each rising edge and pushes the expected
  // outputs for the cycle that follows.
  initial begin
    exp_t e;
    m_t = 0; m_sl = 0; m_sr = 0; m_dl = 0; m_dr = 0; m_blank = 0; m_frame = 0;
    forever begin
      @(posedge clk);
      if (reset_n) begin
        m_t     = m_t + 1;
        m_blank = blank_i;
        m_frame = (m_t % FRM == 0);
        if (m_frame) begin
          m_sl = hex_left_i; m_sr = hex_right_i;
          m_dl = dp_left_i;  m_dr = dp_right_i;
        end
      end
      #3;
      if (!reset_n) begin
        m_t = 0; m_sl = 0; m_sr = 0; m_dl = 0; m_dr = 0; m_blank = 0; m_frame = 0;
      end
      e.t  = m_t;
      e.fr = m_frame;
      model_bank(m_sl, m_dl, 1'b0, e.gl, e.sl);
      model_bank(m_sr, m_dr, 1'b0, e.gr, e.sr);
      model_bank(m_sl, m_dl, 1'b1, e.zgl, e.zsl);
      model_bank(m_sr, m_dr, 1'b1, e.zgr, e.zsr);
      exp_q.push_back(e);
    end
  end

  // Monitor: compares the DUT outputs on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got no expected entry at time %0t, required one", $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (grid_l !== e.gl || seg_l !== e.sl || grid_r !== e.gr ||
            seg_r !== e.sr || frame !== e.fr) begin
          errors++;
          $display("FAIL scan_main t=%0d: got gl=%h sl=%h gr=%h sr=%h fr=%b required gl=%h sl=%h gr=%h sr=%h fr=%b",
                   e.t, grid_l, seg_l, grid_r, seg_r, frame, e.gl, e.sl, e.gr, e.sr, e.fr);
        end
        checks++;
        if (zgrid_l !== e.zgl || zseg_l !== e.zsl || zgrid_r !== e.zgr ||
            zseg_r !== e.zsr || zframe !== e.fr) begin
          errors++;
          $display("FAIL scan_lzb t=%0d: got gl=%h sl=%h gr=%h sr=%h fr=%b required gl=%h sl=%h gr=%h sr=%h fr=%b",
                   e.t, zgrid_l, zseg_l, zgrid_r, zseg_r, zframe, e.zgl, e.zsl, e.zgr, e.zsr, e.fr);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [15:0] rnd_hex();
    logic [15:0] h;
    h = 16'h0;
    for (int k = 0; k < 4; k++)
      h[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return h;
  endfunction

  initial begin
    // Reset is held for 5 clocks, then released. With zero inputs the display
    // shows "0000".
    step(5);
    reset_n = 1'b1;
    step(40);

    // Snapshot: the word changes mid-frame, and the new value appears only in
    // the next frame.
    hex_left_i = 16'h1234;
    step(FRM);
    step(12);
    hex_left_i = 16'h5678;
    step(2 * FRM);

    // Decode sweep on the right bank, with a decimal point on digit 0 only.
    dp_right_i = 4'b0001;
    hex_right_i = 16'h0123; step(FRM);
    hex_right_i = 16'h4567; step(FRM);
    hex_right_i = 16'h89AB; step(FRM);
    hex_right_i = 16'hCDEF; step(2 * FRM);
    dp_right_i = 4'b0000;

    // Blank for one slot.
    blank_i = 1'b1; step(SLOT);
    blank_i = 1'b0; step(FRM);

    // Reset pulse at cnt=5 of idx=2 (21 clocks into the frame).
    begin
      int i;
      for (i = 0; i < 2 * FRM && (m_t % FRM) != 2 * SLOT + 5; i++) step(1);
      checks++;
      if ((m_t % FRM) != 2 * SLOT + 5) begin
        errors++;
        $display("FAIL reset_align: got frame phase %0d, required %0d", m_t % FRM, 2 * SLOT + 5);
      end
    end
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2 * FRM);

    // Random traffic: the data words include frequent zero nibbles so that
    // leading-zero blanking is exercised.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        hex_left_i  = rnd_hex();
        hex_right_i = rnd_hex();
        dp_left_i   = 4'($urandom_range(0, 15));
        dp_right_i  = 4'($urandom_range(0, 15));
      end
      blank_i = ($urandom_range(0, 19) == 0);
      step(1);
    end
    blank_i = 1'b0;

    // Leading-zero cases.
    dp_left_i = 4'hF;
    hex_left_i = 16'h00A0; step(2 * FRM);
    hex_left_i = 16'h0000; step(2 * FRM);

    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
